// File: rtl/alu_wb_buffer.sv
// Execute->writeback buffer: 2-entry FIFO of completed ALU operations plus the
// architectural NZCV register, updated when an operation requesting it is accepted.
module alu_wb_buffer #(
    parameter int unsigned BITS    = 4,
    parameter int unsigned RD_BITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BITS-1:0]    in_result,
    input  logic [3:0]         in_flags,
    input  logic [RD_BITS-1:0] in_rd,
    input  logic               in_we,
    input  logic               in_setf,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BITS-1:0]    out_result,
    output logic [RD_BITS-1:0] out_rd,
    output logic               out_we,
    output logic [3:0]         nzcv,
    output logic [1:0]         count
);

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;

    typedef struct packed {
        logic [BITS-1:0]    result;
        logic [RD_BITS-1:0] rd;
        logic               we;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic               wptr_q, wptr_d;
    logic               rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [3:0]         nzcv_q, nzcv_d;
    logic               ready_q, ready_d;

    logic               push;
    logic               pop;
    logic               valid_c;
    entry_t             head_c;

    assign valid_c = (count_q != CNT_W'(0));
    assign head_c  = mem_q[rptr_q];
    assign push    = in_valid & ready_q;
    assign pop     = valid_c & out_ready;

    // Next-state: flush overrides any push/pop in the same cycle and leaves NZCV alone
    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        nzcv_d  = nzcv_q;
        if (flush) begin
            wptr_d  = 1'b0;
            rptr_d  = 1'b0;
            count_d = CNT_W'(0);
        end else begin
            if (push) begin
                mem_d[wptr_q] = '{result: in_result, rd: in_rd, we: in_we};
                wptr_d        = ~wptr_q;
                if (in_setf) begin
                    nzcv_d = in_flags;
                end
            end
            if (pop) begin
                rptr_d = ~rptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
        ready_d = (count_d != CNT_W'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= CNT_W'(0);
            nzcv_q  <= 4'b0000;
            ready_q <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            nzcv_q  <= nzcv_d;
            ready_q <= ready_d;
        end
    end

    // Head fields are forced to zero when the buffer is empty
    assign in_ready   = ready_q;
    assign out_valid  = valid_c;
    assign out_result = valid_c ? head_c.result : '0;
    assign out_rd     = valid_c ? head_c.rd     : '0;
    assign out_we     = valid_c ? head_c.we     : 1'b0;
    assign nzcv       = nzcv_q;
    assign count      = count_q;

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Directed bench for alu_wb_buffer: vector table for single-edge behaviour plus
// hand-written sequences for pointer wrap and asynchronous reset.
module tb_alu_wb_buffer;

    localparam int unsigned BITS    = 4;
    localparam int unsigned RD_BITS = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [BITS-1:0]    in_result;
    logic [3:0]         in_flags;
    logic [RD_BITS-1:0] in_rd;
    logic               in_we;
    logic               in_setf;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [BITS-1:0]    out_result;
    logic [RD_BITS-1:0] out_rd;
    logic               out_we;
    logic [3:0]         nzcv;
    logic [1:0]         count;

    int checks = 0;
    int errors = 0;

    alu_wb_buffer #(.BITS(BITS), .RD_BITS(RD_BITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_flags   (in_flags),
        .in_rd      (in_rd),
        .in_we      (in_we),
        .in_setf    (in_setf),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_we     (out_we),
        .nzcv       (nzcv),
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [3:0] res;
        logic [3:0] flg;
        logic [3:0] rd;
        logic       we;
        logic       setf;
        logic       fl;
        logic       ordy;
        logic       e_ov;
        logic [3:0] e_res;
        logic [3:0] e_rd;
        logic       e_we;
        logic [3:0] e_nzcv;
        logic [1:0] e_cnt;
        logic       e_irdy;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [3:0] res, input logic [3:0] flg,
                         input logic [3:0] rd, input logic we, input logic setf,
                         input logic fl, input logic ordy);
        in_valid  = iv;
        in_result = res;
        in_flags  = flg;
        in_rd     = rd;
        in_we     = we;
        in_setf   = setf;
        flush     = fl;
        out_ready = ordy;
    endtask

    task automatic chk_all(input string tag, input logic ov, input logic [3:0] res,
                           input logic [3:0] rd, input logic we, input logic [3:0] f,
                           input logic [1:0] cnt, input logic irdy);
        chk({tag, "_out_valid"},  int'(out_valid),  int'(ov));
        chk({tag, "_out_result"}, int'(out_result), int'(res));
        chk({tag, "_out_rd"},     int'(out_rd),     int'(rd));
        chk({tag, "_out_we"},     int'(out_we),     int'(we));
        chk({tag, "_nzcv"},       int'(nzcv),       int'(f));
        chk({tag, "_count"},      int'(count),      int'(cnt));
        chk({tag, "_in_ready"},   int'(in_ready),   int'(irdy));
    endtask

    // Drive at negedge, step one posedge, sample 1 time unit later
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            iv res      flg      rd  we setf fl ordy | ov res      rd  we nzcv     cnt irdy
        vecs[0]  = '{0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0,   0, 4'b0000, 0, 0, 4'b0000, 0, 1};
        vecs[1]  = '{1, 4'b1111, 4'b1000, 3, 1, 1, 0, 1,   1, 4'b1111, 3, 1, 4'b1000, 1, 1};
        vecs[2]  = '{0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1,   0, 4'b0000, 0, 0, 4'b1000, 0, 1};
        vecs[3]  = '{1, 4'b0000, 4'b0100, 1, 1, 1, 0, 0,   1, 4'b0000, 1, 1, 4'b0100, 1, 1};
        vecs[4]  = '{1, 4'b1001, 4'b1001, 2, 1, 1, 0, 0,   1, 4'b0000, 1, 1, 4'b1001, 2, 0};
        vecs[5]  = '{1, 4'b0101, 4'b0010, 4, 0, 1, 0, 0,   1, 4'b0000, 1, 1, 4'b1001, 2, 0};
        vecs[6]  = '{0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1,   1, 4'b1001, 2, 1, 4'b1001, 1, 1};
        vecs[7]  = '{0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1,   0, 4'b0000, 0, 0, 4'b1001, 0, 1};
        vecs[8]  = '{1, 4'b0001, 4'b1000, 5, 0, 1, 0, 0,   1, 4'b0001, 5, 0, 4'b1000, 1, 1};
        vecs[9]  = '{1, 4'b0000, 4'b0100, 6, 1, 0, 0, 1,   1, 4'b0000, 6, 1, 4'b1000, 1, 1};
        vecs[10] = '{0, 4'b0000, 4'b0000, 0, 0, 0, 0, 1,   0, 4'b0000, 0, 0, 4'b1000, 0, 1};
        vecs[11] = '{1, 4'b1010, 4'b0001, 7, 1, 0, 0, 0,   1, 4'b1010, 7, 1, 4'b1000, 1, 1};
        vecs[12] = '{1, 4'b1100, 4'b0000, 8, 0, 0, 0, 0,   1, 4'b1010, 7, 1, 4'b1000, 2, 0};
        vecs[13] = '{1, 4'b0111, 4'b0000, 0, 1, 1, 1, 1,   0, 4'b0000, 0, 0, 4'b1000, 0, 1};
        vecs[14] = '{1, 4'b0011, 4'b0110, 9, 1, 1, 0, 0,   1, 4'b0011, 9, 1, 4'b0110, 1, 1};
        vecs[15] = '{1, 4'b0111, 4'b0000, 0, 1, 1, 1, 0,   0, 4'b0000, 0, 0, 4'b0110, 0, 1};

        rst_n = 1'b0;
        drive(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
        #12;
        chk_all("reset", 0, 4'h0, 4'h0, 0, 4'h0, 2'd0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].iv, vecs[i].res, vecs[i].flg, vecs[i].rd,
                  vecs[i].we, vecs[i].setf, vecs[i].fl, vecs[i].ordy);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_res, vecs[i].e_rd,
                    vecs[i].e_we, vecs[i].e_nzcv, vecs[i].e_cnt, vecs[i].e_irdy);
        end

        // Simultaneous push/pop at count=1, eight times across pointer wrap
        @(negedge clk);
        drive(1, 4'b0001, 4'b0000, 4'hf, 1, 0, 0, 0);
        step();
        chk_all("wrap_seed", 1, 4'b0001, 4'hf, 1, 4'b0110, 2'd1, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(1, 4'(3 + i), 4'b0000, 4'(i), i[0], 0, 0, 1);
            step();
            chk_all($sformatf("wrap%0d", i), 1, 4'(3 + i), 4'(i), i[0], 4'b0110, 2'd1, 1);
        end
        @(negedge clk);
        drive(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 1);
        step();
        chk_all("wrap_drain", 0, 4'h0, 4'h0, 0, 4'b0110, 2'd0, 1);

        // Asynchronous reset between edges with one entry buffered
        @(negedge clk);
        drive(1, 4'b1001, 4'b1001, 4'h2, 1, 1, 0, 0);
        step();
        chk_all("pre_rst", 1, 4'b1001, 4'h2, 1, 4'b1001, 2'd1, 1);
        drive(0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 4'h0, 4'h0, 0, 4'b0000, 2'd0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_all("post_rst", 0, 4'h0, 4'h0, 0, 4'b0000, 2'd0, 1);
        @(negedge clk);
        drive(1, 4'b0110, 4'b0011, 4'h4, 1, 1, 0, 0);
        step();
        chk_all("resume", 1, 4'b0110, 4'h4, 1, 4'b0011, 2'd1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
